eth_rx_frame_filter: RTL and testbench

ETH_RX_FRAME_FILTER -- requirements
Module: eth_rx_frame_filter

---
 rtl/eth_rx_frame_filter.sv | 200 ++++++++++++++++++++
 tb/tb_eth_rx_frame_filter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_filter.sv
// Ethernet RX frame filter: matches destination MAC and EtherType, stores the payload
// speculatively and releases it downstream only once the frame ends without error.
module eth_rx_frame_filter #(
  parameter int          DEPTH            = 2048,
  parameter logic [47:0] LOCAL_MAC        = 48'h020000000001,
  parameter logic [15:0] ETHERTYPE        = 16'h88B5,
  parameter bit          ACCEPT_BROADCAST = 1'b1
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic        cfg_promisc,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [2:0]  drop_pulse,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_PAYLOAD = 2'd1, ST_DROP = 2'd2} state_t;

  logic [1:0]  r_rst_sync;
  logic        w_srst;
  state_t      r_state, w_state_nx;
  logic [3:0]  r_hcnt, w_hcnt_nx;
  logic [47:0] r_mac, w_mac_nx;
  logic [7:0]  r_type_hi, w_type_hi_nx;
  logic [AW:0] r_wr_ptr, w_wr_ptr_nx, r_wr_commit, w_wr_commit_nx, r_rd_ptr;
  logic        w_we, w_ok_inc, w_acc, w_full, w_mac_ok, w_type_ok, w_load;
  logic [2:0]  w_drop_nx, r_drop;
  logic [15:0] r_frames_ok, r_frames_dropped;
  logic [8:0]  r_mem [DEPTH];
  logic        r_m_valid, r_m_last;
  logic [7:0]  r_m_data;

  // Release of reset is re-timed through two flops; the internal sync reset holds until then
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_srst    = ~r_rst_sync[1];
  assign w_acc     = s_axis_tvalid & r_rst_sync[1];
  assign w_mac_ok  = cfg_promisc | (r_mac == LOCAL_MAC) |
                     (ACCEPT_BROADCAST & (r_mac == 48'hFFFF_FFFF_FFFF));
  assign w_type_ok = ({r_type_hi, s_axis_tdata} == ETHERTYPE);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Parser next state, speculative write pointer, commit/rollback and drop cause
  always_comb begin
    w_state_nx     = r_state;
    w_hcnt_nx      = r_hcnt;
    w_mac_nx       = r_mac;
    w_type_hi_nx   = r_type_hi;
    w_wr_ptr_nx    = r_wr_ptr;
    w_wr_commit_nx = r_wr_commit;
    w_we           = 1'b0;
    w_ok_inc       = 1'b0;
    w_drop_nx      = 3'b000;
    if (w_acc) begin
      case (r_state)
        ST_HDR: begin
          if (r_hcnt < 4'd6) w_mac_nx = {r_mac[39:0], s_axis_tdata};
          else               w_mac_nx = r_mac;
          if (r_hcnt == 4'd12) w_type_hi_nx = s_axis_tdata;
          else                 w_type_hi_nx = r_type_hi;
          if (s_axis_tlast) begin
            w_drop_nx  = 3'b010;
            w_hcnt_nx  = 4'd0;
            w_state_nx = ST_HDR;
          end else if (r_hcnt == 4'd13) begin
            w_hcnt_nx = 4'd0;
            if (w_mac_ok && w_type_ok) begin
              w_state_nx = ST_PAYLOAD;
            end else begin
              w_state_nx = ST_DROP;
              w_drop_nx  = 3'b001;
            end
          end else begin
            w_hcnt_nx = r_hcnt + 4'd1;
          end
        end
        ST_PAYLOAD: begin
          if (w_full) begin
            w_wr_ptr_nx = r_wr_commit;
            w_drop_nx   = 3'b100;
            w_state_nx  = s_axis_tlast ? ST_HDR : ST_DROP;
          end else if (s_axis_tlast && s_axis_tuser) begin
            w_wr_ptr_nx = r_wr_commit;
            w_drop_nx   = 3'b010;
            w_state_nx  = ST_HDR;
          end else if (s_axis_tlast) begin
            w_we           = 1'b1;
            w_wr_ptr_nx    = r_wr_ptr + PTR_ONE;
            w_wr_commit_nx = r_wr_ptr + PTR_ONE;
            w_ok_inc       = 1'b1;
            w_state_nx     = ST_HDR;
          end else begin
            w_we        = 1'b1;
            w_wr_ptr_nx = r_wr_ptr + PTR_ONE;
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) w_state_nx = ST_HDR;
          else              w_state_nx = ST_DROP;
        end
        default: begin
          w_state_nx = ST_HDR;
          w_hcnt_nx  = 4'd0;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Parser state, pointers, drop pulse and frame counters
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_HDR;
      r_hcnt           <= 4'd0;
      r_mac            <= 48'd0;
      r_type_hi        <= 8'd0;
      r_wr_ptr         <= '0;
      r_wr_commit      <= '0;
      r_drop           <= 3'b000;
      r_frames_ok      <= 16'd0;
      r_frames_dropped <= 16'd0;
    end else if (w_srst) begin
      r_state          <= ST_HDR;
      r_hcnt           <= 4'd0;
      r_mac            <= 48'd0;
      r_type_hi        <= 8'd0;
      r_wr_ptr         <= '0;
      r_wr_commit      <= '0;
      r_drop           <= 3'b000;
      r_frames_ok      <= 16'd0;
      r_frames_dropped <= 16'd0;
    end else begin
      r_state          <= w_state_nx;
      r_hcnt           <= w_hcnt_nx;
      r_mac            <= w_mac_nx;
      r_type_hi        <= w_type_hi_nx;
      r_wr_ptr         <= w_wr_ptr_nx;
      r_wr_commit      <= w_wr_commit_nx;
      r_drop           <= w_drop_nx;
      r_frames_ok      <= r_frames_ok + {15'd0, w_ok_inc};
      r_frames_dropped <= r_frames_dropped + {15'd0, (|w_drop_nx)};
    end
  end

  // Payload storage; contents past the committed pointer are never read
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  assign w_load = (r_rd_ptr != r_wr_commit) && (!r_m_valid || m_axis_tready);

  // Registered output stage, refilled every cycle the consumer takes a byte
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= 8'd0;
    end else if (w_srst) begin
      r_rd_ptr  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= 8'd0;
    end else if (w_load) begin
      r_rd_ptr  <= r_rd_ptr + PTR_ONE;
      r_m_valid <= 1'b1;
      r_m_last  <= r_mem[r_rd_ptr[AW-1:0]][8];
      r_m_data  <= r_mem[r_rd_ptr[AW-1:0]][7:0];
    end else if (m_axis_tready) begin
      r_m_valid <= 1'b0;
    end else begin
      r_m_valid <= r_m_valid;
    end
  end

  assign s_axis_tready  = r_rst_sync[1];
  assign m_axis_tdata   = r_m_data;
  assign m_axis_tvalid  = r_m_valid;
  assign m_axis_tlast   = r_m_last;
  assign drop_pulse     = r_drop;
  assign frames_ok      = r_frames_ok;
  assign frames_dropped = r_frames_dropped;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Bench for eth_rx_frame_filter: directed scenarios plus randomized frames scored
// against a frame-level reference model (one default DUT, one DEPTH=16 DUT).
module tb_eth_rx_frame_filter;
  localparam logic [47:0] LMAC = 48'h020000000001;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst_n, tv, s_last, s_user, promisc, sel_small;
  logic [7:0]  s_data;
  logic        b_tready, b_mvalid, b_mlast, b_rdy;
  logic [7:0]  b_mdata;
  logic [2:0]  b_drop;
  logic [15:0] b_ok, b_dropped;
  logic        sm_tready, sm_mvalid, sm_mlast, sm_rdy;
  logic [7:0]  sm_mdata;
  logic [2:0]  sm_drop;
  logic [15:0] sm_ok, sm_dropped;
  logic        b_tvalid_in, sm_tvalid_in;

  assign b_tvalid_in  = tv & ~sel_small;
  assign sm_tvalid_in = tv & sel_small;

  eth_rx_frame_filter u_dut (
    .i_clk(clk), .rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(b_tvalid_in),
    .s_axis_tready(b_tready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .cfg_promisc(promisc), .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid),
    .m_axis_tready(b_rdy), .m_axis_tlast(b_mlast), .drop_pulse(b_drop),
    .frames_ok(b_ok), .frames_dropped(b_dropped));

  eth_rx_frame_filter #(.DEPTH(16)) u_small (
    .i_clk(clk), .rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(sm_tvalid_in),
    .s_axis_tready(sm_tready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .cfg_promisc(promisc), .m_axis_tdata(sm_mdata), .m_axis_tvalid(sm_mvalid),
    .m_axis_tready(sm_rdy), .m_axis_tlast(sm_mlast), .drop_pulse(sm_drop),
    .frames_ok(sm_ok), .frames_dropped(sm_dropped));

  logic [8:0] obs_b[$], obs_s[$];
  logic [2:0] drp_b[$], drp_s[$];

  // Record every output handshake and every drop pulse cycle
  always @(negedge clk) begin
    if (b_mvalid && b_rdy)   obs_b.push_back({b_mlast, b_mdata});
    if (sm_mvalid && sm_rdy) obs_s.push_back({sm_mlast, sm_mdata});
    if (b_drop != 3'b000)    drp_b.push_back(b_drop);
    if (sm_drop != 3'b000)   drp_s.push_back(sm_drop);
  end

  int          n_chk = 0, n_pass = 0;
  int          obs_rd = 0, exp_rd = 0, drp_rd = 0, edrp_rd = 0;
  logic [8:0]  exp_out[$];
  logic [2:0]  exp_drp[$];
  logic [15:0] exp_ok = 16'd0, exp_dropped = 16'd0;
  logic [7:0]  tx_q[$];
  bit          rnd_rdy = 1'b0, gaps = 1'b0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) b_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] ty, input int plen, input int start);
    tx_q.delete();
    for (int k = 0; k < 6; k++) tx_q.push_back(dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) tx_q.push_back(8'($urandom));
    tx_q.push_back(ty[15:8]);
    tx_q.push_back(ty[7:0]);
    for (int k = 0; k < plen; k++)
      tx_q.push_back((start < 0) ? 8'($urandom) : 8'(start + k));
  endtask

  task automatic send(input int n, input bit tu);
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) step();
      tv     = 1'b1;
      s_data = tx_q[i];
      s_last = (i == tx_q.size() - 1);
      s_user = tu & (i == tx_q.size() - 1);
      step();
      tv     = 1'b0;
      s_last = 1'b0;
      s_user = 1'b0;
    end
  endtask

  // Frame-level expectation: runts are errors, then address/type filter, then tuser
  task automatic model(input bit tu, input bit pm);
    int          n;
    logic [47:0] dst;
    logic [15:0] ty;
    bit          mac_ok;
    n = tx_q.size();
    if (n <= 14) begin
      exp_drp.push_back(3'b010);
      exp_dropped++;
      return;
    end
    dst    = {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5]};
    ty     = {tx_q[12], tx_q[13]};
    mac_ok = pm || (dst == LMAC) || (dst == 48'hFFFF_FFFF_FFFF);
    if (!(mac_ok && ty == 16'h88B5)) begin
      exp_drp.push_back(3'b001);
      exp_dropped++;
    end else if (tu) begin
      exp_drp.push_back(3'b010);
      exp_dropped++;
    end else begin
      for (int i = 14; i < n; i++) exp_out.push_back({(i == n - 1), tx_q[i]});
      exp_ok++;
    end
  endtask

  task automatic cmp_out(input string tag);
    int guard = 0;
    int nobs, nexp;
    while ((obs_b.size() - obs_rd) < (exp_out.size() - exp_rd) && guard < 8000) begin
      step();
      guard++;
    end
    repeat (4) step();
    nobs = obs_b.size() - obs_rd;
    nexp = exp_out.size() - exp_rd;
    chk({tag, "_count"}, 48'(nobs), 48'(nexp));
    for (int i = 0; i < ((nobs < nexp) ? nobs : nexp); i++)
      chk({tag, "_byte"}, 48'(obs_b[obs_rd+i]), 48'(exp_out[exp_rd+i]));
    obs_rd = obs_b.size();
    exp_rd = exp_out.size();
  endtask

  task automatic cmp_drops(input string tag);
    int nobs, nexp;
    repeat (3) step();
    nobs = drp_b.size() - drp_rd;
    nexp = exp_drp.size() - edrp_rd;
    chk({tag, "_drops"}, 48'(nobs), 48'(nexp));
    for (int i = 0; i < ((nobs < nexp) ? nobs : nexp); i++)
      chk({tag, "_cause"}, 48'(drp_b[drp_rd+i]), 48'(exp_drp[edrp_rd+i]));
    drp_rd  = drp_b.size();
    edrp_rd = exp_drp.size();
    chk({tag, "_ok"}, 48'(b_ok), 48'(exp_ok));
    chk({tag, "_dropped"}, 48'(b_dropped), 48'(exp_dropped));
  endtask

  initial begin
    tv = 1'b0; s_last = 1'b0; s_user = 1'b0; s_data = 8'd0; promisc = 1'b0;
    sel_small = 1'b0; b_rdy = 1'b0; sm_rdy = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_tready", 48'(b_tready), 48'd0);
    chk("rst_tvalid", 48'(b_mvalid), 48'd0);
    chk("rst_tlast", 48'(b_mlast), 48'd0);
    chk("rst_tdata", 48'(b_mdata), 48'd0);
    chk("rst_drop", 48'(b_drop), 48'd0);
    chk("rst_ok", 48'(b_ok), 48'd0);
    chk("rst_dropped", 48'(b_dropped), 48'd0);
    rst_n = 1'b1;
    step();
    chk("sync_edge1_tready", 48'(b_tready), 48'd0);
    step();
    chk("sync_edge2_tready", 48'(b_tready), 48'd1);

    // Good unicast frame with payload 00..3F
    b_rdy = 1'b1;
    build(LMAC, 16'h88B5, 64, 0);
    send(tx_q.size(), 1'b0); model(1'b0, 1'b0);
    cmp_out("unicast"); cmp_drops("unicast");

    // Wrong EtherType, then promiscuous foreign MAC
    build(LMAC, 16'h0800, 64, 0);
    send(tx_q.size(), 1'b0); model(1'b0, 1'b0);
    cmp_out("badtype"); cmp_drops("badtype");
    promisc = 1'b1;
    build(48'h112233445566, 16'h88B5, 12, 8'h50);
    send(tx_q.size(), 1'b0); model(1'b0, 1'b1);
    promisc = 1'b0;
    cmp_out("promisc"); cmp_drops("promisc");

    // Errored frame then a 10-byte frame, checking first-byte latency
    b_rdy = 1'b0;
    build(LMAC, 16'h88B5, 20, 8'h90);
    send(tx_q.size(), 1'b1); model(1'b1, 1'b0);
    build(48'hFFFF_FFFF_FFFF, 16'h88B5, 10, 8'hA0);
    send(tx_q.size(), 1'b0); model(1'b0, 1'b0);
    step(); step();
    chk("latency_tvalid", 48'(b_mvalid), 48'd1);
    chk("latency_tdata", 48'(b_mdata), 48'hA0);
    repeat (5) step();
    chk("stall_tdata", 48'(b_mdata), 48'hA0);
    b_rdy = 1'b1;
    cmp_out("tuser"); cmp_drops("tuser");

    // Runt with tlast on header byte 9, then a normal frame
    build(LMAC, 16'h88B5, 0, 0);
    while (tx_q.size() > 10) void'(tx_q.pop_back());
    send(tx_q.size(), 1'b0); model(1'b0, 1'b0);
    build(LMAC, 16'h88B5, 5, 8'hC0);
    send(tx_q.size(), 1'b0); model(1'b0, 1'b0);
    cmp_out("runt"); cmp_drops("runt");

    // Randomized frames with gaps and downstream backpressure
    rnd_rdy = 1'b1; gaps = 1'b1;
    for (int f = 0; f < 25; f++) begin
      logic [47:0] dst;
      logic [15:0] ty;
      bit          tu, pm;
      case ($urandom_range(0, 3))
        0: dst = LMAC;
        1: dst = 48'hFFFF_FFFF_FFFF;
        2: dst = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        default: dst = LMAC ^ 48'h1;
      endcase
      ty = ($urandom_range(0, 9) < 7) ? 16'h88B5 : (16'h88B5 ^ 16'($urandom_range(1, 65535)));
      pm = ($urandom_range(0, 5) == 0);
      tu = ($urandom_range(0, 7) == 0);
      build(dst, ty, $urandom_range(1, 60), -1);
      if ($urandom_range(0, 7) == 0) begin
        int n = $urandom_range(1, 14);
        while (tx_q.size() > n) void'(tx_q.pop_back());
      end
      promisc = pm;
      send(tx_q.size(), tu); model(tu, pm);
      promisc = 1'b0;
    end
    rnd_rdy = 1'b0; gaps = 1'b0; b_rdy = 1'b1;
    cmp_out("random"); cmp_drops("random");

    // DEPTH=16 instance: overflow, then a frame that fills it exactly
    sel_small = 1'b1; sm_rdy = 1'b0;
    build(LMAC, 16'h88B5, 20, 0);
    send(tx_q.size(), 1'b0);
    repeat (3) step();
    chk("ovf_drops", 48'(drp_s.size()), 48'd1);
    if (drp_s.size() > 0) chk("ovf_cause", 48'(drp_s[0]), 48'(3'b100));
    chk("ovf_dropped", 48'(sm_dropped), 48'd1);
    sm_rdy = 1'b1;
    repeat (30) step();
    chk("ovf_no_output", 48'(obs_s.size()), 48'd0);
    build(LMAC, 16'h88B5, 16, 8'h40);
    send(tx_q.size(), 1'b0);
    repeat (25) step();
    chk("full16_count", 48'(obs_s.size()), 48'd16);
    for (int i = 0; i < ((obs_s.size() < 16) ? obs_s.size() : 16); i++)
      chk("full16_byte", 48'(obs_s[i]), 48'({(i == 15), 8'(8'h40 + i)}));
    chk("full16_ok", 48'(sm_ok), 48'd1);
    chk("full16_dropped", 48'(sm_dropped), 48'd1);
    sel_small = 1'b0;

    // Reset mid-payload with a committed frame still waiting downstream
    b_rdy = 1'b0;
    build(LMAC, 16'h88B5, 8, 8'h80);
    send(tx_q.size(), 1'b0);
    build(LMAC, 16'h88B5, 30, 8'hE0);
    send(19, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tready", 48'(b_tready), 48'd0);
    chk("midrst_tvalid", 48'(b_mvalid), 48'd0);
    chk("midrst_tlast", 48'(b_mlast), 48'd0);
    chk("midrst_tdata", 48'(b_mdata), 48'd0);
    chk("midrst_drop", 48'(b_drop), 48'd0);
    chk("midrst_ok", 48'(b_ok), 48'd0);
    chk("midrst_dropped", 48'(b_dropped), 48'd0);
    exp_ok = 16'd0; exp_dropped = 16'd0;
    repeat (3) step();
    obs_rd = obs_b.size(); drp_rd = drp_b.size();
    rst_n = 1'b1;
    b_rdy = 1'b1;
    repeat (40) step();
    cmp_out("post_rst_idle");
    chk("post_rst_tvalid", 48'(b_mvalid), 48'd0);
    build(LMAC, 16'h88B5, 6, 8'h30);
    send(tx_q.size(), 1'b0); model(1'b0, 1'b0);
    cmp_out("post_rst"); cmp_drops("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
